fix_checksum_gen: RTL and testbench

FIX_CHECKSUM_GEN -- requirements
Module: fix_checksum_gen

---
 rtl/fix_checksum_gen.sv | 134 +++++++++++++
 tb/tb_fix_checksum_gen.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fix_checksum_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fix_checksum_gen                                             |
// | Description : Accumulates a modulo-256 sum over FIX message bytes, then    |
// |               converts it to three ASCII decimal digits, which are sent    |
// |               hundreds first over a valid/ready handshake.                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fix_checksum_gen (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic [7:0] data_i,
    input  logic       data_valid_i,
    input  logic       freeze_i,
    output logic [7:0] chksm_o,
    output logic       chksm_valid_o,
    input  logic       chksm_rdy_i,
    output logic [7:0] sum_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_ACCUM  = 3'd1;
    localparam logic [2:0] c_CONV_H = 3'd2;
    localparam logic [2:0] c_CONV_T = 3'd3;
    localparam logic [2:0] c_OUT_H  = 3'd4;
    localparam logic [2:0] c_OUT_T  = 3'd5;
    localparam logic [2:0] c_OUT_U  = 3'd6;

    localparam logic [7:0] c_ASCII_ZERO = 8'h30;

    logic [2:0] r_state;
    logic [7:0] r_sum;
    logic [7:0] r_rem;
    logic [3:0] r_hund;
    logic [3:0] r_tens;

    logic [7:0] w_load;
    logic [3:0] w_digit;

    // Value a start_i cycle loads into the sum: the byte on that cycle, if any.
    assign w_load = data_valid_i ? data_i : 8'd0;

    // Main FSM: accumulate, convert by repeated subtraction, then emit digits.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_sum   <= 8'd0;
            r_rem   <= 8'd0;
            r_hund  <= 4'd0;
            r_tens  <= 4'd0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start_i) begin
                        r_sum <= w_load;
                        if (freeze_i) begin
                            // Single-byte message: start and freeze together.
                            r_rem   <= w_load;
                            r_hund  <= 4'd0;
                            r_tens  <= 4'd0;
                            r_state <= c_CONV_H;
                        end else begin
                            r_state <= c_ACCUM;
                        end
                    end
                end
                c_ACCUM: begin
                    if (start_i) begin
                        r_sum <= w_load;
                        if (freeze_i) begin
                            r_rem   <= w_load;
                            r_hund  <= 4'd0;
                            r_tens  <= 4'd0;
                            r_state <= c_CONV_H;
                        end
                    end else if (freeze_i) begin
                        // The byte presented with freeze is not counted.
                        r_rem   <= r_sum;
                        r_hund  <= 4'd0;
                        r_tens  <= 4'd0;
                        r_state <= c_CONV_H;
                    end else if (data_valid_i) begin
                        r_sum <= r_sum + data_i;
                    end
                end
                c_CONV_H: begin
                    if (r_rem >= 8'd100) begin
                        r_rem  <= r_rem - 8'd100;
                        r_hund <= r_hund + 4'd1;
                    end else begin
                        r_state <= c_CONV_T;
                    end
                end
                c_CONV_T: begin
                    if (r_rem >= 8'd10) begin
                        r_rem  <= r_rem - 8'd10;
                        r_tens <= r_tens + 4'd1;
                    end else begin
                        r_state <= c_OUT_H;
                    end
                end
                c_OUT_H: if (chksm_rdy_i) r_state <= c_OUT_T;
                c_OUT_T: if (chksm_rdy_i) r_state <= c_OUT_U;
                c_OUT_U: if (chksm_rdy_i) r_state <= c_IDLE;
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // Select the digit for the current output state; units is the remainder.
    always_comb begin
        w_digit = 4'd0;
        case (r_state)
            c_OUT_H: w_digit = r_hund;
            c_OUT_T: w_digit = r_tens;
            c_OUT_U: w_digit = r_rem[3:0];
            default: w_digit = 4'd0;
        endcase
    end

    assign chksm_o       = c_ASCII_ZERO + {4'd0, w_digit};
    // Valid and done decode the state alone; done marks the units-digit state,
    // so with the consumer ready it is a single-cycle pulse on acceptance.
    assign chksm_valid_o = (r_state == c_OUT_H) || (r_state == c_OUT_T) ||
                           (r_state == c_OUT_U);
    assign done_o        = (r_state == c_OUT_U);
    assign busy_o        = (r_state != c_IDLE);
    assign sum_o         = r_sum;

endmodule
`default_nettype wire

// File: tb/tb_fix_checksum_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fix_checksum_gen                                          |
// | Description : Directed table-driven bench for fix_checksum_gen plus        |
// |               hand-written backpressure, restart and reset sequences.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_fix_checksum_gen;

    logic       clk;
    logic       rst;
    logic       start_i;
    logic [7:0] data_i;
    logic       data_valid_i;
    logic       freeze_i;
    logic [7:0] chksm_o;
    logic       chksm_valid_o;
    logic       chksm_rdy_i;
    logic [7:0] sum_o;
    logic       busy_o;
    logic       done_o;

    int n_vec;
    int n_err;

    typedef struct packed {
        logic [2:0]  n;      // number of bytes
        logic        comb;   // start and freeze on the same cycle (n == 1)
        logic [31:0] bytes;  // byte i in bits [8*i +: 8]
        logic [7:0]  sum;
        logic [23:0] digs;   // hundreds in [23:16], tens [15:8], units [7:0]
        logic [3:0]  lat;    // freeze cycle to first valid
    } vec_t;

    vec_t vecs[7];

    fix_checksum_gen dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start_i),
        .data_i        (data_i),
        .data_valid_i  (data_valid_i),
        .freeze_i      (freeze_i),
        .chksm_o       (chksm_o),
        .chksm_valid_o (chksm_valid_o),
        .chksm_rdy_i   (chksm_rdy_i),
        .sum_o         (sum_o),
        .busy_o        (busy_o),
        .done_o        (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic clear_inputs();
        start_i      = 1'b0;
        freeze_i     = 1'b0;
        data_valid_i = 1'b0;
        data_i       = 8'd0;
    endtask

    // Drive a message and wait for the first valid digit; returns at a negedge.
    task automatic start_msg(input logic [2:0] n, input logic comb,
                             input logic [31:0] bytes, input int exp_lat,
                             input string nm);
        int lat;
        for (int i = 0; i < int'(n); i++) begin
            @(negedge clk);
            start_i      = (i == 0);
            data_valid_i = 1'b1;
            data_i       = bytes[8*i +: 8];
            freeze_i     = comb;
        end
        if (!comb) begin
            @(negedge clk);
            clear_inputs();
            freeze_i = 1'b1;
        end
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            clear_inputs();
        end while (!chksm_valid_o && lat < 20);
        check({nm, " latency"}, lat, exp_lat);
    endtask

    // Read three digits with the consumer always ready.
    task automatic read_digits(input logic [23:0] digs, input string nm);
        check({nm, " digit H"}, chksm_o, digs[23:16]);
        check({nm, " done early"}, done_o, 0);
        @(posedge clk); @(negedge clk);
        check({nm, " digit T"}, chksm_o, digs[15:8]);
        @(posedge clk); @(negedge clk);
        check({nm, " digit U"}, chksm_o, digs[7:0]);
        check({nm, " done"}, done_o, 1);
        @(posedge clk); @(negedge clk);
        check({nm, " idle after"}, busy_o, 0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        vecs[0] = '{3'd3, 1'b0, 32'h00_01_3D_38, 8'h76, 24'h31_31_38, 4'd5};
        vecs[1] = '{3'd2, 1'b0, 32'h00_00_01_FF, 8'h00, 24'h30_30_30, 4'd3};
        vecs[2] = '{3'd1, 1'b1, 32'h00_00_00_FF, 8'hFF, 24'h32_35_35, 4'd10};
        vecs[3] = '{3'd1, 1'b0, 32'h00_00_00_64, 8'h64, 24'h31_30_30, 4'd4};
        vecs[4] = '{3'd2, 1'b0, 32'h00_00_00_09, 8'h09, 24'h30_30_39, 4'd3};
        vecs[5] = '{3'd3, 1'b0, 32'h00_0A_80_80, 8'h0A, 24'h30_31_30, 4'd4};
        vecs[6] = '{3'd2, 1'b0, 32'h00_00_37_C8, 8'hFF, 24'h32_35_35, 4'd10};

        // Reset with a simultaneous start: reset must win.
        rst          = 1'b1;
        chksm_rdy_i  = 1'b1;
        start_i      = 1'b1;
        freeze_i     = 1'b0;
        data_valid_i = 1'b1;
        data_i       = 8'h55;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset chksm", chksm_o, 8'h30);
        check("reset valid", chksm_valid_o, 0);
        check("reset busy", busy_o, 0);
        check("reset done", done_o, 0);
        check("reset sum", sum_o, 0);
        rst = 1'b0;
        clear_inputs();

        // Freeze in IDLE is ignored.
        @(negedge clk);
        freeze_i = 1'b1;
        @(negedge clk);
        freeze_i = 1'b0;
        check("idle freeze busy", busy_o, 0);

        for (int v = 0; v < 7; v++) begin
            start_msg(vecs[v].n, vecs[v].comb, vecs[v].bytes, int'(vecs[v].lat),
                      $sformatf("vec%0d", v));
            check($sformatf("vec%0d sum", v), sum_o, vecs[v].sum);
            read_digits(vecs[v].digs, $sformatf("vec%0d", v));
        end

        // Backpressure during OUT_T, sum 118.
        start_msg(3'd3, 1'b0, 32'h00_01_3D_38, 5, "bp");
        check("bp digit H", chksm_o, 8'h31);
        @(posedge clk); @(negedge clk);
        chksm_rdy_i = 1'b0;
        check("bp digit T", chksm_o, 8'h31);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); @(negedge clk);
            check("bp hold digit", chksm_o, 8'h31);
            check("bp hold valid", chksm_valid_o, 1);
        end
        chksm_rdy_i = 1'b1;
        @(posedge clk); @(negedge clk);
        check("bp digit U", chksm_o, 8'h38);
        check("bp done", done_o, 1);
        @(posedge clk); @(negedge clk);
        check("bp idle after", busy_o, 0);

        // Restart in ACCUM, then a start during OUT_H is ignored.
        @(negedge clk);
        start_i = 1'b1; data_valid_i = 1'b1; data_i = 8'h10;
        @(negedge clk);
        start_i = 1'b0; data_i = 8'h20;
        start_msg(3'd1, 1'b0, 32'h0000_0005, 3, "restart");
        check("restart sum", sum_o, 8'h05);
        chksm_rdy_i = 1'b0;
        start_i = 1'b1; data_valid_i = 1'b1; data_i = 8'h44; freeze_i = 1'b1;
        @(posedge clk); @(negedge clk);
        clear_inputs();
        check("ignore start digit", chksm_o, 8'h30);
        check("ignore start valid", chksm_valid_o, 1);
        check("ignore start sum", sum_o, 8'h05);
        chksm_rdy_i = 1'b1;
        read_digits(24'h30_30_35, "restart");

        // Reset while in CONV_T, then a clean message.
        @(negedge clk);
        start_i = 1'b1; data_valid_i = 1'b1; data_i = 8'hFF; freeze_i = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        clear_inputs();
        check("conv busy", busy_o, 1);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        check("midrst busy", busy_o, 0);
        check("midrst valid", chksm_valid_o, 0);
        check("midrst sum", sum_o, 0);
        check("midrst chksm", chksm_o, 8'h30);
        start_msg(3'd3, 1'b0, 32'h00_01_3D_38, 5, "post rst");
        check("post rst sum", sum_o, 8'h76);
        read_digits(24'h31_31_38, "post rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
